inst_queue: RTL and testbench

Instruction queue between the fetch path (PC unit + instruction cache) and the decoder. Buffers fetched (pc, instruction) pairs in a small FIFO and presents them to the decoder through a valid/ready handshake. Back-pressures the PC unit through `fetch_stall`. On a ROB redirect it flushes all contents and discards wrong-path fetches until the first instruction at the redirect target arrives.

---
 rtl/inst_queue_pkg.sv | 12 +
 rtl/inst_queue_sync_fifo.sv | 48 ++++
 rtl/inst_queue.sv | 90 +++++++++
 tb/tb_inst_queue.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/inst_queue_pkg.sv
// Shared widths and FSM encoding for the instruction queue between fetch and decode.
package inst_queue_pkg;

  localparam int unsigned InstAddrWidth = 32;
  localparam int unsigned InstWidth     = 32;

  typedef enum logic [0:0] {
    IqRun      = 1'b0,
    IqRedirect = 1'b1
  } iq_state_e;

endpackage

// File: rtl/inst_queue_sync_fifo.sv
// Circular FIFO storage with head/tail pointers and an occupancy count; flush empties it.
module inst_queue_sync_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64,
  localparam int unsigned PtrW = $clog2(DEPTH),
  localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic [WIDTH-1:0] push_data,
  input  logic            pop,
  input  logic            flush,
  output logic [CntW-1:0] count,
  output logic [WIDTH-1:0] head_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  head_q, tail_q;
  logic [CntW-1:0]  count_q;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) tail_q <= tail_q + PtrW'(1);
      if (pop)  head_q <= head_q + PtrW'(1);
      if (push && !pop) begin
        count_q <= count_q + CntW'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CntW'(1);
      end
    end
  end

  // Storage is not reset; the pointers and count alone define what is valid.
  always_ff @(posedge clk) begin
    if (!rst && !flush && push) begin
      mem_q[tail_q] <= push_data;
    end
  end

  assign count     = count_q;
  assign head_data = mem_q[head_q];

endmodule

// File: rtl/inst_queue.sv
// Fetch-to-decode instruction queue with back-pressure and redirect handling: after a flush,
// wrong-path fetches are dropped until the word at the redirect target arrives.
module inst_queue
  import inst_queue_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = InstAddrWidth,
  parameter int unsigned INST_W = InstWidth
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_valid,
  input  logic [ADDR_W-1:0] fetch_pc,
  input  logic [INST_W-1:0] fetch_inst,
  output logic              fetch_stall,
  input  logic              flush,
  input  logic [ADDR_W-1:0] flush_npc,
  output logic              dec_valid,
  input  logic              dec_ready,
  output logic [ADDR_W-1:0] dec_pc,
  output logic [ADDR_W-1:0] dec_npc,
  output logic [INST_W-1:0] dec_inst,
  output logic              ovf
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [CntW-1:0] CntFull  = CntW'(DEPTH);
  localparam logic [CntW-1:0] CntStall = CntW'(DEPTH - 1);

  iq_state_e         state_q;
  logic [ADDR_W-1:0] exp_pc_q;
  logic              ovf_q;

  logic [CntW-1:0]          count;
  logic [ADDR_W+INST_W-1:0] head_data;
  logic [ADDR_W-1:0]        head_pc;
  logic [INST_W-1:0]        head_inst;

  logic in_run, pop, run_accept, run_drop, target_hit, push;

  always_comb begin
    in_run     = (state_q == IqRun);
    dec_valid  = in_run && (count != '0);
    pop        = dec_valid && dec_ready && !flush;
    run_accept = in_run && !flush && fetch_valid && ((count < CntFull) || pop);
    run_drop   = in_run && !flush && fetch_valid && !run_accept;
    target_hit = !in_run && !flush && fetch_valid && (fetch_pc == exp_pc_q);
    push       = run_accept || target_hit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IqRun;
      exp_pc_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (run_drop) ovf_q <= 1'b1;
      if (flush) begin
        state_q  <= IqRedirect;
        exp_pc_q <= flush_npc;
      end else if (target_hit) begin
        state_q <= IqRun;
      end
    end
  end

  inst_queue_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ADDR_W + INST_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({fetch_pc, fetch_inst}),
    .pop       (pop),
    .flush     (flush),
    .count     (count),
    .head_data (head_data)
  );

  assign {head_pc, head_inst} = head_data;

  // Skid slot: stall one entry early so a word already in flight still fits.
  assign fetch_stall = in_run && (count >= CntStall);
  assign dec_pc      = dec_valid ? head_pc : '0;
  assign dec_inst    = dec_valid ? head_inst : '0;
  assign dec_npc     = dec_valid ? head_pc + ADDR_W'(4) : '0;
  assign ovf         = ovf_q;

endmodule

// File: tb/tb_inst_queue.sv
// Table-driven bench for inst_queue with a scoreboard of accepted fetches checked at each pop.
module tb_inst_queue;

  logic        clk = 1'b0;
  logic        rst, fetch_valid, flush, dec_ready;
  logic [31:0] fetch_pc, fetch_inst, flush_npc;
  logic        fetch_stall, dec_valid, ovf;
  logic [31:0] dec_pc, dec_npc, dec_inst;

  inst_queue #(
    .DEPTH  (4),
    .ADDR_W (32),
    .INST_W (32)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_valid (fetch_valid),
    .fetch_pc    (fetch_pc),
    .fetch_inst  (fetch_inst),
    .fetch_stall (fetch_stall),
    .flush       (flush),
    .flush_npc   (flush_npc),
    .dec_valid   (dec_valid),
    .dec_ready   (dec_ready),
    .dec_pc      (dec_pc),
    .dec_npc     (dec_npc),
    .dec_inst    (dec_inst),
    .ovf         (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        fv;
    logic [31:0] fpc;
    logic        flush;
    logic [31:0] fnpc;
    logic        rdy;
    logic        acc;
    logic        e_valid;
    logic [31:0] e_pc;
    logic        e_stall;
    logic        e_ovf;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  vec_t   vecs[$];
  entry_t sb[$];
  int     checks = 0;
  int     errors = 0;

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return pc ^ 32'h1357_9BDF;
  endfunction

  function automatic vec_t mk(input logic r, input logic fv, input logic [31:0] fpc,
                              input logic fl, input logic [31:0] fnpc, input logic rdy,
                              input logic acc, input logic ev, input logic [31:0] epc,
                              input logic est, input logic eovf);
    vec_t v;
    v.rst = r; v.fv = fv; v.fpc = fpc; v.flush = fl; v.fnpc = fnpc; v.rdy = rdy;
    v.acc = acc; v.e_valid = ev; v.e_pc = epc; v.e_stall = est; v.e_ovf = eovf;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Compare the presented head against the oldest accepted fetch and retire it.
  task automatic sb_pop(input string tag);
    entry_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_sb_empty: got pop with pc %h expected no entry", tag, dec_pc);
    end else begin
      e = sb.pop_front();
      chk({tag, "_sb_pc"}, dec_pc, e.pc);
      chk({tag, "_sb_inst"}, dec_inst, e.inst);
    end
  endtask

  task automatic drive(input logic r, input logic fv, input logic [31:0] fpc, input logic fl,
                       input logic [31:0] fnpc, input logic rdy);
    rst = r; fetch_valid = fv; fetch_pc = fpc; fetch_inst = inst_of(fpc);
    flush = fl; flush_npc = fnpc; dec_ready = rdy;
  endtask

  initial begin
    //        rst fv fpc           fl fnpc          rdy acc ev epc           st ovf
    // pipelined stream
    vecs.push_back(mk(0, 1, 32'h00, 0, 32'h0, 1, 1, 0, 32'h00, 0, 0));
    vecs.push_back(mk(0, 1, 32'h04, 0, 32'h0, 1, 1, 1, 32'h00, 0, 0));
    vecs.push_back(mk(0, 1, 32'h08, 0, 32'h0, 1, 1, 1, 32'h04, 0, 0));
    vecs.push_back(mk(0, 0, 32'h00, 0, 32'h0, 1, 0, 1, 32'h08, 0, 0));
    vecs.push_back(mk(0, 0, 32'h00, 0, 32'h0, 0, 0, 0, 32'h00, 0, 0));
    // fill to full, then overflow
    vecs.push_back(mk(0, 1, 32'h10, 0, 32'h0, 0, 1, 0, 32'h00, 0, 0));
    vecs.push_back(mk(0, 1, 32'h14, 0, 32'h0, 0, 1, 1, 32'h10, 0, 0));
    vecs.push_back(mk(0, 1, 32'h18, 0, 32'h0, 0, 1, 1, 32'h10, 0, 0));
    vecs.push_back(mk(0, 1, 32'h1C, 0, 32'h0, 0, 1, 1, 32'h10, 1, 0));
    vecs.push_back(mk(0, 1, 32'h20, 0, 32'h0, 0, 0, 1, 32'h10, 1, 0));
    vecs.push_back(mk(0, 0, 32'h00, 0, 32'h0, 0, 0, 1, 32'h10, 1, 1));
    // reset with fetch, flush and ready all high
    vecs.push_back(mk(1, 1, 32'h99, 1, 32'h200, 1, 0, 1, 32'h10, 1, 1));
    // full queue with simultaneous push and pop
    vecs.push_back(mk(0, 1, 32'h30, 0, 32'h0, 0, 1, 0, 32'h00, 0, 0));
    vecs.push_back(mk(0, 1, 32'h34, 0, 32'h0, 0, 1, 1, 32'h30, 0, 0));
    vecs.push_back(mk(0, 1, 32'h38, 0, 32'h0, 0, 1, 1, 32'h30, 0, 0));
    vecs.push_back(mk(0, 1, 32'h3C, 0, 32'h0, 0, 1, 1, 32'h30, 1, 0));
    vecs.push_back(mk(0, 1, 32'h50, 0, 32'h0, 1, 1, 1, 32'h30, 1, 0));
    vecs.push_back(mk(0, 1, 32'h54, 0, 32'h0, 1, 1, 1, 32'h34, 1, 0));
    vecs.push_back(mk(0, 0, 32'h00, 0, 32'h0, 1, 0, 1, 32'h38, 1, 0));
    vecs.push_back(mk(0, 0, 32'h00, 0, 32'h0, 1, 0, 1, 32'h3C, 1, 0));
    vecs.push_back(mk(0, 0, 32'h00, 0, 32'h0, 0, 0, 1, 32'h50, 0, 0));
    vecs.push_back(mk(0, 0, 32'h00, 0, 32'h0, 1, 0, 1, 32'h50, 0, 0));
    vecs.push_back(mk(0, 1, 32'h58, 0, 32'h0, 0, 1, 1, 32'h54, 0, 0));
    // flush to 0x40, wrong-path fetches discarded
    vecs.push_back(mk(0, 1, 32'h5C, 1, 32'h40, 1, 0, 1, 32'h54, 0, 0));
    vecs.push_back(mk(0, 1, 32'h18, 0, 32'h0, 1, 0, 0, 32'h00, 0, 0));
    vecs.push_back(mk(0, 1, 32'h1C, 0, 32'h0, 1, 0, 0, 32'h00, 0, 0));
    vecs.push_back(mk(0, 1, 32'h40, 0, 32'h0, 1, 1, 0, 32'h00, 0, 0));
    vecs.push_back(mk(0, 1, 32'h44, 0, 32'h0, 1, 1, 1, 32'h40, 0, 0));
    vecs.push_back(mk(0, 0, 32'h00, 0, 32'h0, 0, 0, 1, 32'h44, 0, 0));
    // second flush while redirecting
    vecs.push_back(mk(0, 0, 32'h00, 1, 32'h40, 0, 0, 1, 32'h44, 0, 0));
    vecs.push_back(mk(0, 1, 32'h40, 1, 32'h80, 0, 0, 0, 32'h00, 0, 0));
    vecs.push_back(mk(0, 1, 32'h40, 0, 32'h0, 1, 0, 0, 32'h00, 0, 0));
    vecs.push_back(mk(0, 1, 32'h80, 0, 32'h0, 1, 1, 0, 32'h00, 0, 0));
    vecs.push_back(mk(0, 0, 32'h00, 0, 32'h0, 0, 0, 1, 32'h80, 0, 0));
    // reach count 3 with ovf set, then reset with flush
    vecs.push_back(mk(0, 1, 32'h84, 0, 32'h0, 0, 1, 1, 32'h80, 0, 0));
    vecs.push_back(mk(0, 1, 32'h88, 0, 32'h0, 0, 1, 1, 32'h80, 0, 0));
    vecs.push_back(mk(0, 1, 32'h8C, 0, 32'h0, 0, 1, 1, 32'h80, 1, 0));
    vecs.push_back(mk(0, 1, 32'h90, 0, 32'h0, 0, 0, 1, 32'h80, 1, 0));
    vecs.push_back(mk(0, 0, 32'h00, 0, 32'h0, 1, 0, 1, 32'h80, 1, 1));
    vecs.push_back(mk(1, 1, 32'h94, 1, 32'h300, 1, 0, 1, 32'h84, 1, 1));
    vecs.push_back(mk(0, 1, 32'h00, 0, 32'h0, 1, 1, 0, 32'h00, 0, 0));
    vecs.push_back(mk(0, 0, 32'h00, 0, 32'h0, 1, 0, 1, 32'h00, 0, 0));
    vecs.push_back(mk(0, 0, 32'h00, 0, 32'h0, 1, 0, 0, 32'h00, 0, 0));

    drive(1, 0, 32'h0, 0, 32'h0, 0);
    repeat (2) @(posedge clk);

    foreach (vecs[i]) begin
      vec_t  v;
      string t;
      v = vecs[i];
      t = $sformatf("r%0d", i);
      @(negedge clk);
      drive(v.rst, v.fv, v.fpc, v.flush, v.fnpc, v.rdy);
      #1;
      chk({t, "_valid"}, {31'd0, dec_valid}, {31'd0, v.e_valid});
      chk({t, "_pc"}, dec_pc, v.e_pc);
      chk({t, "_npc"}, dec_npc, v.e_valid ? v.e_pc + 32'd4 : 32'd0);
      chk({t, "_stall"}, {31'd0, fetch_stall}, {31'd0, v.e_stall});
      chk({t, "_ovf"}, {31'd0, ovf}, {31'd0, v.e_ovf});
      if (!v.rst && !v.flush && v.e_valid && v.rdy) sb_pop(t);
      if (v.rst || v.flush) sb.delete();
      if (v.acc) sb.push_back('{pc: v.fpc, inst: inst_of(v.fpc)});
    end

    // npc wraps at the top of the address space; head holds while not ready
    @(negedge clk);
    drive(0, 1, 32'hFFFF_FFFC, 0, 32'h0, 0);
    sb.push_back('{pc: 32'hFFFF_FFFC, inst: inst_of(32'hFFFF_FFFC)});
    @(negedge clk);
    drive(0, 0, 32'h0, 0, 32'h0, 0);
    for (int k = 0; k < 5 && !dec_valid; k++) @(negedge clk);
    #1;
    if (!dec_valid) begin
      checks++;
      errors++;
      $display("FAIL wrap_wait: got dec_valid 0 expected 1 within 5 cycles");
    end else begin
      chk("wrap_npc", dec_npc, 32'h0);
      chk("wrap_pc", dec_pc, 32'hFFFF_FFFC);
      @(negedge clk);
      dec_ready = 1'b1;
      #1;
      chk("wrap_hold_pc", dec_pc, 32'hFFFF_FFFC);
      sb_pop("wrap");
      @(negedge clk);
      dec_ready = 1'b0;
      #1;
      chk("wrap_drained", {31'd0, dec_valid}, 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
